pipe_ctrl: RTL and testbench

- Central stall/flush/redirect controller for the 5-stage in-order core.
- Merges per-stage stall requests into a stall vector for the PC and the pipeline registers.
- Arbitrates between a branch redirect resolved in EX and a trap redirect raised in MEM, then drives the PC's `stallreq`/`br`/`bt` inputs.
- Holds a redirect pending while a multi-cycle stall is in progress, and keeps stall/redirect performance counters.

---
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush/redirect controller for the 5-stage core: merges stage stall
// requests, arbitrates branch vs trap redirects and holds one pending redirect.
module pipe_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              br_ex,
  input  logic [ADDR_W-1:0] bt_ex,
  input  logic              trap_req,
  input  logic [ADDR_W-1:0] trap_vec,
  output logic [4:0]        stall,
  output logic [4:0]        flush,
  output logic              br,
  output logic [ADDR_W-1:0] bt,
  output logic              pending,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [15:0]       redir_cnt
);

  localparam logic [4:0] STALL_MEM  = 5'b01111;
  localparam logic [4:0] STALL_EX   = 5'b00111;
  localparam logic [4:0] STALL_ID   = 5'b00011;
  localparam logic [4:0] FLUSH_TRAP = 5'b01111;
  localparam logic [4:0] FLUSH_BR   = 5'b00110;

  typedef enum logic [0:0] {RUN, HOLD} state_t;

  state_t            state, state_nx;
  logic              pend_trap, pend_trap_nx;
  logic [ADDR_W-1:0] pend_tgt, pend_tgt_nx;
  logic [4:0]        base_stall, base_flush;
  logic              eff_trap, release_c;
  logic [ADDR_W-1:0] eff_tgt;

  // Highest requesting stage decides both the hold vector and the bubble slot.
  always_comb begin
    base_stall = 5'b00000;
    base_flush = 5'b00000;
    if (stallreq_mem) begin
      base_stall = STALL_MEM;
      base_flush = 5'b10000;
    end else if (stallreq_ex) begin
      base_stall = STALL_EX;
      base_flush = 5'b01000;
    end else if (stallreq_id) begin
      base_stall = STALL_ID;
      base_flush = 5'b00100;
    end
  end

  // A trap arriving while a branch is held replaces it (the trap is older).
  assign eff_trap  = pend_trap | trap_req;
  assign eff_tgt   = (trap_req && !pend_trap) ? trap_vec : pend_tgt;
  assign release_c = eff_trap ? !stallreq_mem : (!stallreq_ex && !stallreq_mem);

  always_comb begin
    state_nx     = state;
    pend_trap_nx = pend_trap;
    pend_tgt_nx  = pend_tgt;
    stall        = base_stall;
    flush        = base_flush;
    br           = 1'b0;
    bt           = '0;
    pending      = 1'b0;
    unique case (state)
      RUN: begin
        if (trap_req && !stallreq_mem) begin
          br    = 1'b1;
          bt    = trap_vec;
          stall = 5'b00000;
          flush = FLUSH_TRAP;
        end else if (trap_req) begin
          pend_trap_nx = 1'b1;
          pend_tgt_nx  = trap_vec;
          state_nx     = HOLD;
          pending      = 1'b1;
        end else if (br_ex && !stallreq_ex && !stallreq_mem) begin
          br    = 1'b1;
          bt    = bt_ex;
          stall = 5'b00000;
          flush = FLUSH_BR;
        end else if (br_ex) begin
          pend_trap_nx = 1'b0;
          pend_tgt_nx  = bt_ex;
          state_nx     = HOLD;
          pending      = 1'b1;
        end
      end
      HOLD: begin
        if (release_c) begin
          br           = 1'b1;
          bt           = eff_tgt;
          stall        = 5'b00000;
          flush        = eff_trap ? FLUSH_TRAP : FLUSH_BR;
          pend_trap_nx = 1'b0;
          pend_tgt_nx  = '0;
          state_nx     = RUN;
        end else begin
          pending      = 1'b1;
          pend_trap_nx = eff_trap;
          pend_tgt_nx  = eff_tgt;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      pend_trap <= 1'b0;
      pend_tgt  <= '0;
    end else begin
      state     <= state_nx;
      pend_trap <= pend_trap_nx;
      pend_tgt  <= pend_tgt_nx;
    end
  end

  // Performance counters: stall cycles saturate, redirects wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      if (stall[0] && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (br)
        redir_cnt <= redir_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; counter width reduced so saturation is reachable.
module tb_pipe_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              stallreq_id, stallreq_ex, stallreq_mem;
  logic              br_ex, trap_req;
  logic [ADDR_W-1:0] bt_ex, trap_vec;
  logic [4:0]        stall, flush;
  logic              br, pending;
  logic [ADDR_W-1:0] bt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [15:0]       redir_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int br_seen;

  pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .br_ex(br_ex), .bt_ex(bt_ex), .trap_req(trap_req), .trap_vec(trap_vec),
    .stall(stall), .flush(flush), .br(br), .bt(bt), .pending(pending),
    .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    br_ex = 0; bt_ex = '0; trap_req = 0; trap_vec = '0;
  endtask

  initial begin
    rst = 1'b0;
    clr();
    // 1: reset and idle
    #3;
    check("rst_stall", 64'(stall), 64'h0);
    check("rst_flush", 64'(flush), 64'h0);
    check("rst_br", 64'(br), 64'h0);
    check("rst_scnt", 64'(stall_cnt), 64'h0);
    check("rst_rcnt", 64'(redir_cnt), 64'h0);
    #9 rst = 1'b1;
    repeat (10) cyc();
    check("idle_scnt", 64'(stall_cnt), 64'h0);
    check("idle_rcnt", 64'(redir_cnt), 64'h0);

    // 2: load-use stall, then branch that overrides it
    stallreq_id = 1; #1;
    check("id_stall", 64'(stall), 64'h03);
    check("id_flush", 64'(flush), 64'h04);
    cyc();
    check("id_scnt", 64'(stall_cnt), 64'h1);
    br_ex = 1; bt_ex = 32'h80; #1;
    check("br_br", 64'(br), 64'h1);
    check("br_bt", 64'(bt), 64'h80);
    check("br_stall", 64'(stall), 64'h0);
    check("br_flush", 64'(flush), 64'h06);
    cyc();
    check("br_rcnt", 64'(redir_cnt), 64'h1);
    check("br_scnt", 64'(stall_cnt), 64'h1);
    clr();

    // 3: branch held under a 3-cycle EX stall
    stallreq_ex = 1; br_ex = 1; bt_ex = 32'h100;
    for (int i = 1; i <= 3; i++) begin
      #1;
      check($sformatf("ex%0d_pend", i), 64'(pending), 64'h1);
      check($sformatf("ex%0d_stall", i), 64'(stall), 64'h07);
      check($sformatf("ex%0d_br", i), 64'(br), 64'h0);
      cyc();
      br_ex = 0; bt_ex = '0;
    end
    check("ex1_flush_last", 64'(flush), 64'h08);
    stallreq_ex = 0; #1;
    check("ex4_br", 64'(br), 64'h1);
    check("ex4_bt", 64'(bt), 64'h100);
    check("ex4_pend", 64'(pending), 64'h0);
    cyc();
    check("ex_scnt", 64'(stall_cnt), 64'h4);
    check("ex_rcnt", 64'(redir_cnt), 64'h2);

    // 4: trap beats a same-cycle branch
    trap_req = 1; trap_vec = 32'h200; br_ex = 1; bt_ex = 32'h300; #1;
    check("trap_br", 64'(br), 64'h1);
    check("trap_bt", 64'(bt), 64'h200);
    check("trap_flush", 64'(flush), 64'h0F);
    check("trap_stall", 64'(stall), 64'h0);
    cyc();
    clr();
    br_seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (br) br_seen++;
      cyc();
    end
    check("trap_no_late_br", 64'(br_seen), 64'h0);
    check("trap_rcnt", 64'(redir_cnt), 64'h3);

    // 5: pending branch replaced by trap under MEM stall
    stallreq_mem = 1; br_ex = 1; bt_ex = 32'h400; #1;
    check("m1_pend", 64'(pending), 64'h1);
    check("m1_stall", 64'(stall), 64'h0F);
    check("m1_flush", 64'(flush), 64'h10);
    check("m1_br", 64'(br), 64'h0);
    cyc();
    br_ex = 0; trap_req = 1; trap_vec = 32'h500; #1;
    check("m2_br", 64'(br), 64'h0);
    cyc();
    trap_req = 0; #1;
    check("m3_br", 64'(br), 64'h0);
    check("m3_pend", 64'(pending), 64'h1);
    cyc();
    stallreq_mem = 0; #1;
    check("m4_br", 64'(br), 64'h1);
    check("m4_bt", 64'(bt), 64'h500);
    check("m4_flush", 64'(flush), 64'h0F);
    cyc();
    clr(); #1;
    check("m5_br", 64'(br), 64'h0);
    check("m5_pend", 64'(pending), 64'h0);
    cyc();
    check("m_rcnt", 64'(redir_cnt), 64'h4);
    check("m_scnt", 64'(stall_cnt), 64'h7);

    // 6: async reset discards a pending trap
    stallreq_mem = 1; trap_req = 1; trap_vec = 32'h600; #1;
    check("r_pend0", 64'(pending), 64'h1);
    cyc();
    trap_req = 0; #1;
    check("r_pend1", 64'(pending), 64'h1);
    #2 rst = 1'b0; #1;
    check("r_pend_async", 64'(pending), 64'h0);
    check("r_scnt", 64'(stall_cnt), 64'h0);
    check("r_rcnt", 64'(redir_cnt), 64'h0);
    #1 rst = 1'b1;
    stallreq_mem = 0;
    br_seen = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (br) br_seen++;
    end
    check("r_no_br", 64'(br_seen), 64'h0);

    // stall counter saturation
    stallreq_id = 1;
    repeat (254) cyc();
    check("sat_pre", 64'(stall_cnt), 64'hFE);
    repeat (40) cyc();
    check("sat_max", 64'(stall_cnt), 64'hFF);
    clr();
    cyc();
    check("sat_hold", 64'(stall_cnt), 64'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
